// File: rtl/sha256_round_ctrl_if.sv
// Block-in / digest-out handshake bundle for the SHA-256 round controller.
interface sha256_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [511:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_digest;
  logic         busy;

  modport master (output in_valid, in_first, in_data, out_ready,
                  input  in_ready, out_valid, out_digest, busy);
  modport slave  (input  in_valid, in_first, in_data, out_ready,
                  output in_ready, out_valid, out_digest, busy);
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block compressor: one round per clock, message schedule as a
// 16-word shift register, chaining H registers across blocks.
module sha256_f32 (
  input  logic [7:0][31:0] st,   // st[0] = a ... st[7] = h
  input  logic [31:0]      w,
  input  logic [31:0]      k,
  output logic [7:0][31:0] nxt
);
  logic [31:0] bs0, bs1, ch, mj, t1, t2;
  always_comb begin
    bs1 = {st[4][5:0], st[4][31:6]} ^ {st[4][10:0], st[4][31:11]} ^ {st[4][24:0], st[4][31:25]};
    bs0 = {st[0][1:0], st[0][31:2]} ^ {st[0][12:0], st[0][31:13]} ^ {st[0][21:0], st[0][31:22]};
    ch  = (st[4] & st[5]) ^ (~st[4] & st[6]);
    mj  = (st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]);
    t1  = st[7] + bs1 + ch + k + w;
    t2  = bs0 + mj;
    nxt = {st[6:4], st[3] + t1, st[2:0], t1 + t2};
  end
endmodule

module sha256_round_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  sha256_round_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  state_t            state, state_n;
  logic [5:0]        t;
  logic [7:0][31:0]  wv, wv_nxt, hv;
  logic [15:0][31:0] sched;
  logic [31:0]       ss0, ss1, w_new, kt;

  sha256_f32 u_f32 (.st(wv), .w(sched[0]), .k(kt), .nxt(wv_nxt));

  always_comb begin
    kt    = K_TAB[t];
    ss0   = {sched[1][6:0], sched[1][31:7]} ^ {sched[1][17:0], sched[1][31:18]} ^ (sched[1] >> 3);
    ss1   = {sched[14][16:0], sched[14][31:17]} ^ {sched[14][18:0], sched[14][31:19]} ^ (sched[14] >> 10);
    w_new = ss1 + sched[9] + ss0 + sched[0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid)    state_n = ROUND;
      ROUND:   if (t == 6'd63)      state_n = FINAL;
      FINAL:                        state_n = DONE;
      DONE:    if (bus.out_ready)   state_n = IDLE;
      default:                      state_n = IDLE;
    endcase
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_digest = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t     <= '0;
      wv    <= '0;
      hv    <= IV;
      sched <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          t  <= '0;
          wv <= bus.in_first ? IV : hv;
          if (bus.in_first) hv <= IV;
          for (int i = 0; i < 16; i++) sched[i] <= bus.in_data[511-32*i -: 32];
        end
        ROUND: begin
          wv    <= wv_nxt;
          t     <= t + 6'd1;
          sched <= {w_new, sched[15:1]};
        end
        FINAL: for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
        default: ;
      endcase
    end
  end
endmodule
